// File: rtl/auto_jogador_memoria_pkg.sv
// Shared types and constants for the memory-game auto player.
// State encoding is 5 bits wide so it lines up with the game's own state register.
package auto_jogador_pkg;

    typedef enum logic [4:0] {
        OCIOSO     = 5'd0,
        ESPERA_LED = 5'd1,
        CAPTURA    = 5'd2,
        PRESSIONA  = 5'd3,
        SOLTA      = 5'd4,
        FIM        = 5'd5
    } estado_t;

    localparam int HOLD_PADRAO    = 100;
    localparam int PAUSA_PADRAO   = 100;
    localparam int MAX_SEQ_PADRAO = 16;

    localparam logic [3:0] PADRAO_ERRO = 4'b1100;

    function automatic logic eh_one_hot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/auto_jogador_memoria_contador_ciclos.sv
// Down-counter timing press and pause phases; load wins over enable.
// done is high during the last cycle of a loaded interval (count == 1).
module contador_ciclos #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] valor,
    input  logic         enable,
    output logic         done
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= valor;
        end else if (enable && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done = (cnt_q == W'(1));

endmodule

// File: rtl/auto_jogador_memoria.sv
// Watches the game's LEDs, stores the shown sequence and replays it on the buttons.
// First press appears on the edge that samples vez_jogador rising; each press/pause is timed exactly.
module auto_jogador_memoria
    import auto_jogador_pkg::*;
#(
    parameter int HOLD_CICLOS  = HOLD_PADRAO,
    parameter int PAUSA_CICLOS = PAUSA_PADRAO,
    parameter int MAX_SEQ      = MAX_SEQ_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilitar,
    input  logic [3:0] leds,
    input  logic       vez_jogador,
    input  logic       fim_jogo,
    input  logic       injetar_erro,
    output logic [3:0] botoes,
    output logic       ocupado,
    output logic [4:0] contagem,
    output logic       erro_captura
);

    localparam int TMAX = (HOLD_CICLOS > PAUSA_CICLOS) ? HOLD_CICLOS : PAUSA_CICLOS;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int IW   = (MAX_SEQ > 1) ? $clog2(MAX_SEQ) : 1;
    localparam logic [4:0] MAX_CONT = 5'(MAX_SEQ);

    estado_t    estado_q, estado_d;
    logic [4:0] contagem_q, contagem_d;
    logic [4:0] indice_q, indice_d;
    logic [4:0] indice_prox;
    logic [3:0] botoes_q, botoes_d;
    logic       erro_q, erro_d;
    logic [3:0] leds_ant_q;
    logic       vez_ant_q;
    logic       mem_we;
    logic       tmr_load, tmr_done, tmr_en;
    logic [TW-1:0] tmr_valor;
    logic       led_sobe, vez_sobe;

    logic [3:0] mem [MAX_SEQ];

    assign led_sobe    = (leds != 4'd0) && (leds_ant_q == 4'd0);
    assign vez_sobe    = vez_jogador && !vez_ant_q;
    assign indice_prox = indice_q + 5'd1;
    assign tmr_en      = (estado_q == PRESSIONA) || (estado_q == SOLTA);

    contador_ciclos #(.W(TW)) u_tmr (
        .clock  (clock),
        .reset  (reset),
        .load   (tmr_load),
        .valor  (tmr_valor),
        .enable (tmr_en),
        .done   (tmr_done)
    );

    always_comb begin
        estado_d   = estado_q;
        contagem_d = contagem_q;
        indice_d   = indice_q;
        botoes_d   = 4'd0;
        erro_d     = erro_q;
        mem_we     = 1'b0;
        tmr_load   = 1'b0;
        tmr_valor  = TW'(HOLD_CICLOS);

        if (fim_jogo && (estado_q != OCIOSO)) begin
            estado_d = FIM;
        end else if (!habilitar) begin
            estado_d   = OCIOSO;
            contagem_d = 5'd0;
            erro_d     = 1'b0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    estado_d   = ESPERA_LED;
                    contagem_d = 5'd0;
                end
                ESPERA_LED: begin
                    // The player's turn outranks a simultaneous LED edge.
                    if (vez_sobe) begin
                        indice_d = 5'd0;
                        if (contagem_q != 5'd0) begin
                            estado_d = PRESSIONA;
                            botoes_d = injetar_erro ? PADRAO_ERRO : mem[0];
                            tmr_load = 1'b1;
                        end
                    end else if (led_sobe) begin
                        estado_d = CAPTURA;
                        if (!eh_one_hot(leds))
                            erro_d = 1'b1;
                        if (contagem_q >= MAX_CONT) begin
                            erro_d = 1'b1;
                        end else begin
                            mem_we     = 1'b1;
                            contagem_d = contagem_q + 5'd1;
                        end
                    end
                end
                CAPTURA: begin
                    if (leds == 4'd0)
                        estado_d = ESPERA_LED;
                    else if ((leds != leds_ant_q) || !eh_one_hot(leds))
                        erro_d = 1'b1;
                end
                PRESSIONA: begin
                    if (tmr_done) begin
                        estado_d  = SOLTA;
                        tmr_load  = 1'b1;
                        tmr_valor = TW'(PAUSA_CICLOS);
                    end else begin
                        botoes_d = botoes_q;
                    end
                end
                SOLTA: begin
                    if (tmr_done) begin
                        if (indice_prox < contagem_q) begin
                            estado_d = PRESSIONA;
                            indice_d = indice_prox;
                            botoes_d = mem[indice_prox[IW-1:0]];
                            tmr_load = 1'b1;
                        end else begin
                            estado_d   = ESPERA_LED;
                            contagem_d = 5'd0;
                        end
                    end
                end
                FIM: begin
                    if (!fim_jogo)
                        estado_d = OCIOSO;
                end
                default: estado_d = OCIOSO;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q   <= OCIOSO;
            contagem_q <= 5'd0;
            indice_q   <= 5'd0;
            botoes_q   <= 4'd0;
            erro_q     <= 1'b0;
            leds_ant_q <= 4'd0;
            vez_ant_q  <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            contagem_q <= contagem_d;
            indice_q   <= indice_d;
            botoes_q   <= botoes_d;
            erro_q     <= erro_d;
            leds_ant_q <= leds;
            vez_ant_q  <= vez_jogador;
        end
    end

    // Sequence storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (reset && mem_we)
            mem[contagem_q[IW-1:0]] <= leds;
    end

    assign botoes       = botoes_q;
    assign ocupado      = (estado_q != OCIOSO);
    assign contagem     = contagem_q;
    assign erro_captura = erro_q;

endmodule

// File: tb/tb_auto_jogador_memoria.sv
// Randomized scoreboard bench: captured sequences are modelled as a queue of LED values,
// expected presses are queued at stimulus time and checked by an independent button monitor.
module tb_auto_jogador_memoria;

    localparam int HOLD  = 100;
    localparam int PAUSA = 37;
    localparam int MAXS  = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       habilitar = 1'b0;
    logic [3:0] leds = 4'd0;
    logic       vez_jogador = 1'b0;
    logic       fim_jogo = 1'b0;
    logic       injetar_erro = 1'b0;
    logic [3:0] botoes;
    logic       ocupado;
    logic [4:0] contagem;
    logic       erro_captura;

    auto_jogador_memoria #(
        .HOLD_CICLOS  (HOLD),
        .PAUSA_CICLOS (PAUSA),
        .MAX_SEQ      (MAXS)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .habilitar    (habilitar),
        .leds         (leds),
        .vez_jogador  (vez_jogador),
        .fim_jogo     (fim_jogo),
        .injetar_erro (injetar_erro),
        .botoes       (botoes),
        .ocupado      (ocupado),
        .contagem     (contagem),
        .erro_captura (erro_captura)
    );

    typedef struct {
        logic [3:0] valor;
        int         inicio;
        int         duracao;
    } press_t;

    press_t     esperado[$];
    logic [3:0] capturados[$];
    bit         erro_modelo = 1'b0;
    int         testes = 0;
    int         falhas = 0;
    int         cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic check(input string nome, input int atual, input int esp);
        testes++;
        if (atual != esp) begin
            falhas++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nome, atual, esp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Button monitor: every press must match the next queued expectation.
    logic [3:0] b_ant = 4'd0;
    int         dur = 0;
    bit         ativo = 1'b0;
    press_t     atual;

    always @(negedge clock) begin
        if (botoes != 4'd0 && b_ant == 4'd0) begin
            dur = 1;
            if (esperado.size() == 0) begin
                testes++;
                falhas++;
                ativo = 1'b0;
                $display("FAIL press_inesperado: botoes=%b with no press queued (cycle %0d)", botoes, cyc);
            end else begin
                atual = esperado.pop_front();
                ativo = 1'b1;
                check("press_valor", botoes, atual.valor);
                check("press_inicio", cyc, atual.inicio);
            end
        end else if (botoes != 4'd0) begin
            dur++;
            if (ativo)
                check("press_estavel", botoes, atual.valor);
        end else if (b_ant != 4'd0 && ativo) begin
            check("press_duracao", dur, atual.duracao);
            ativo = 1'b0;
        end
        b_ant = botoes;
    end

    // Shows one LED pulse while the block is waiting for LEDs; the model records it.
    task automatic mostra(input logic [3:0] v);
        leds = v;
        tick(3);
        leds = 4'd0;
        tick(2);
        if ($countones(v) != 1)
            erro_modelo = 1'b1;
        if (capturados.size() < MAXS)
            capturados.push_back(v);
        else
            erro_modelo = 1'b1;
    endtask

    task automatic replay(input bit inj, input bit ruido);
        int     n;
        int     base;
        press_t p;
        n = capturados.size();
        injetar_erro = inj;
        vez_jogador  = 1'b1;
        base = cyc + 1;
        for (int i = 0; i < n; i++) begin
            p.valor   = (i == 0 && inj) ? 4'b1100 : capturados[i];
            p.inicio  = base + i * (HOLD + PAUSA);
            p.duracao = HOLD;
            esperado.push_back(p);
        end
        tick(1);
        injetar_erro = 1'b0;
        if (ruido && n > 0) begin
            tick(10);
            leds = 4'b0010;
            tick(3);
            leds = 4'd0;
            tick(n * (HOLD + PAUSA) - 9);
        end else begin
            tick(n * (HOLD + PAUSA) + 4);
        end
        vez_jogador = 1'b0;
        tick(1);
        check("fila_vazia", esperado.size(), 0);
        check("contagem_pos_replay", contagem, 0);
        check("botoes_pos_replay", botoes, 0);
        capturados.delete();
    endtask

    task automatic limpa();
        habilitar = 1'b0;
        tick(1);
        habilitar = 1'b1;
        tick(2);
        capturados.delete();
        erro_modelo = 1'b0;
    endtask

    initial begin
        press_t p;
        int     n;
        logic [3:0] v;

        tick(3);
        check("reset_botoes", botoes, 0);
        check("reset_ocupado", ocupado, 0);
        check("reset_contagem", contagem, 0);
        check("reset_erro", erro_captura, 0);
        reset = 1'b1;
        habilitar = 1'b1;
        tick(2);
        check("ocupado_ativo", ocupado, 1);

        mostra(4'b0001);
        check("contagem_um", contagem, 1);
        replay(1'b0, 1'b0);

        mostra(4'b0001);
        mostra(4'b0100);
        mostra(4'b1000);
        check("contagem_tres", contagem, 3);
        replay(1'b0, 1'b1);

        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(0, 5);
            for (int i = 0; i < n; i++) begin
                v = 4'b0001 << $urandom_range(0, 3);
                mostra(v);
            end
            check("contagem_rand", contagem, capturados.size());
            check("erro_rand", erro_captura, erro_modelo);
            replay($urandom_range(0, 3) == 0, 1'b1);
        end

        mostra(4'b0001);
        replay(1'b1, 1'b0);
        fim_jogo = 1'b1;
        tick(1);
        check("fim_ocupado", ocupado, 1);
        check("fim_botoes", botoes, 0);
        tick(3);
        check("fim_mantem", ocupado, 1);
        fim_jogo = 1'b0;
        tick(1);
        check("fim_para_ocioso", ocupado, 0);
        tick(1);
        check("ocioso_para_espera", ocupado, 1);

        for (int i = 0; i < 17; i++)
            mostra(4'b0001 << (i % 4));
        check("overflow_contagem", contagem, 16);
        check("overflow_erro", erro_captura, erro_modelo);
        replay(1'b0, 1'b0);
        check("erro_pegajoso", erro_captura, 1);

        habilitar = 1'b0;
        tick(1);
        check("desab_erro", erro_captura, 0);
        check("desab_ocupado", ocupado, 0);
        check("desab_contagem", contagem, 0);
        habilitar = 1'b1;
        tick(2);
        capturados.delete();
        erro_modelo = 1'b0;

        mostra(4'b0011);
        check("nao_one_hot_erro", erro_captura, erro_modelo);
        check("nao_one_hot_contagem", contagem, 1);
        limpa();

        leds = 4'b0001;
        tick(2);
        leds = 4'b0010;
        tick(2);
        leds = 4'd0;
        tick(2);
        check("troca_led_erro", erro_captura, 1);
        check("troca_led_contagem", contagem, 1);
        limpa();

        mostra(4'b1000);
        vez_jogador = 1'b1;
        p.valor = 4'b1000;
        p.inicio = cyc + 1;
        p.duracao = 50;
        esperado.push_back(p);
        tick(50);
        reset = 1'b0;
        vez_jogador = 1'b0;
        tick(1);
        check("rst_press_botoes", botoes, 0);
        check("rst_press_ocupado", ocupado, 0);
        check("rst_press_contagem", contagem, 0);
        check("rst_press_erro", erro_captura, 0);
        reset = 1'b1;
        tick(3);
        capturados.delete();

        mostra(4'b0010);
        mostra(4'b0001);
        vez_jogador = 1'b1;
        p.valor = 4'b0010;
        p.inicio = cyc + 1;
        p.duracao = 30;
        esperado.push_back(p);
        tick(30);
        habilitar = 1'b0;
        vez_jogador = 1'b0;
        tick(1);
        check("desab_replay_ocupado", ocupado, 0);
        check("desab_replay_botoes", botoes, 0);
        check("desab_replay_contagem", contagem, 0);
        tick(HOLD + PAUSA);
        check("fila_final", esperado.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testes, falhas);
        $finish;
    end

endmodule

// File: doc/auto_jogador_memoria.md
AUTO_JOGADOR_MEMORIA -- requirements
Module: auto_jogador_memoria

Interface
REQ-001 Parameter HOLD_CICLOS, default 100, clock cycles each button press is held.
REQ-002 Parameter PAUSA_CICLOS, default 100, clock cycles of all-zero buttons after each press.
REQ-003 Parameter MAX_SEQ, default 16, capacity of the captured-sequence memory.
REQ-004 clock  in  1  single system clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset (reset=0 resets on the next rising edge).
REQ-006 habilitar  in  1  enables automatic play; low forces OCIOSO.
REQ-007 leds  in  4  game LED outputs; one-hot while a sequence element is shown, 0 otherwise.
REQ-008 vez_jogador  in  1  high while the game waits for player moves.
REQ-009 fim_jogo  in  1  game ended (ganhou or perdeu).
REQ-010 injetar_erro  in  1  when set, the first press of the next replay is replaced by 4'b1100.
REQ-011 botoes  out  4  registered button drive to the game.
REQ-012 ocupado  out  1  high in any state other than OCIOSO.
REQ-013 contagem  out  5  number of elements captured in the current round.
REQ-014 erro_captura  out  1  sticky capture-fault flag.

Function
REQ-015 States SHALL be OCIOSO, ESPERA_LED, CAPTURA, PRESSIONA, SOLTA, FIM.
REQ-016 OCIOSO -> ESPERA_LED when habilitar=1; contagem cleared on that transition.
REQ-017 ESPERA_LED: on cycle where leds!=0 and previous-cycle leds==0, write leds to mem[contagem], increment contagem, go to CAPTURA.
REQ-018 CAPTURA -> ESPERA_LED when leds==0; leds changing to a different nonzero value, or a non-one-hot value, SHALL set erro_captura.
REQ-019 Capture with contagem==MAX_SEQ SHALL set erro_captura, not write memory, not increment contagem.
REQ-020 ESPERA_LED with vez_jogador rising (sampled 1, previous 0) SHALL start replay at index 0; injetar_erro sampled on the same edge.
REQ-021 Replay latency: botoes = mem[0] (or 4'b1100 if injected) from the edge after vez_jogador rise is sampled, for exactly HOLD_CICLOS cycles (PRESSIONA).
REQ-022 SOLTA: botoes=0 for exactly PAUSA_CICLOS cycles; then next index in PRESSIONA, or after index contagem-1 -> ESPERA_LED with contagem cleared.
REQ-023 Replay with contagem==0 SHALL issue no press and return to ESPERA_LED.
REQ-024 Injected error affects only the first press; remaining presses replay mem[1..].
REQ-025 fim_jogo=1 in any non-OCIOSO state -> FIM next edge, botoes=0; FIM -> OCIOSO when fim_jogo=0.
REQ-026 habilitar=0 in any state -> OCIOSO next edge, botoes=0, contagem=0, erro_captura cleared.
REQ-027 Priority per edge: reset > fim_jogo > habilitar=0 > normal transitions.
REQ-028 LED edges during PRESSIONA/SOLTA SHALL be ignored (no capture).
REQ-029 botoes SHALL never be nonzero outside PRESSIONA.
REQ-030 Timer width SHALL hold max(HOLD_CICLOS, PAUSA_CICLOS); contagem width 5 bits, saturating at MAX_SEQ.

Reset
REQ-031 reset=0: state OCIOSO, botoes=0, ocupado=0, contagem=0, erro_captura=0, timer=0, previous-leds register=0.
REQ-032 reset mid-press SHALL drop botoes to 0 on that same edge; memory contents need not be cleared.

Structure
REQ-033 Package auto_jogador_pkg SHALL hold state encoding (5-bit, matching the game's Eatual width), default HOLD/PAUSA/MAX_SEQ constants, and the 4'b1100 error pattern.
REQ-034 One sub-module contador_ciclos (load, enable, done) SHALL time PRESSIONA and SOLTA.
REQ-035 Sequence memory SHALL be an internal MAX_SEQ x 4 register array.

Verification
REQ-036 Single LED 4'b0001 shown, then vez_jogador rise -> botoes=4'b0001 for 100 cycles, then 0 for 100 cycles, back to ESPERA_LED, contagem=0.
REQ-037 Sequence 0001,0100,1000 then vez_jogador -> three presses in that order, each 100 high/100 low; connected to the game in mode 00 for 16 rounds -> ganhou.
REQ-038 injetar_erro=1 with one captured LED -> botoes=4'b1100 for 100 cycles; game asserts perdeu; block enters FIM, then OCIOSO when fim_jogo drops.
REQ-039 17 LED pulses before vez_jogador -> erro_captura=1, contagem=16; leds=4'b0011 -> erro_captura=1.
REQ-040 reset=0 at cycle 50 of a press -> botoes=0 next edge, all outputs at reset values; habilitar=0 mid-replay -> OCIOSO, botoes=0.
